tl_rx_vc_read_ctrl: RTL and testbench
=====================================

// Module: tl_rx_vc_read_ctrl
// PURPOSE
//  Read-side controller of one RX virtual-channel buffer. Pops a committed TLP (header entry, then its
//  payload entries) from the VC header/data buffers and presents it to the application-side egress as
//  valid/ready header and data streams. Drives the buffer read-pointer increments and the credit-release
//  pulses returned to RX flow control. Sits between the VC buffers/buffer control and the AXI master bridge.
// PARAMETERS
//  HDR_WIDTH       128  header entry width; DW0 at [HDR_WIDTH-1 -: 32]
//  DATA_WIDTH      256  data entry width (one beat); DW_PER_BEAT = DATA_WIDTH/32 (power of 2)
//  BEAT_CNT_WIDTH  8    beat counter width; must hold 1024/DW_PER_BEAT
// PORTS
//  i_clk            in   1               clock
//  i_n_rst          in   1               asynchronous active-low reset
//  i_hdr_empty      in   1               header buffer empty flag
//  i_data_empty     in   1               data buffer empty flag
//  i_hdr_rdata      in   HDR_WIDTH       header entry at current read pointer (combinational)
//  i_data_rdata     in   DATA_WIDTH      data entry at current read pointer (combinational)
//  o_r_hdr_inc      out  1               header read-pointer increment (1-cycle pulse)
//  o_r_data_inc     out  1               data read-pointer increment (1-cycle pulse)
//  o_hdr_valid      out  1               header available to egress
//  i_hdr_ready      in   1               egress accepts header
//  o_hdr            out  HDR_WIDTH       registered header
//  o_data_valid     out  1               data beat available
//  i_data_ready     in   1               egress accepts beat
//  o_data           out  DATA_WIDTH      data beat (= i_data_rdata)
//  o_data_keep      out  DATA_WIDTH/32   per-DW valid mask, bit0 = lowest DW
//  o_data_last      out  1               final beat of TLP payload
//  o_cr_hdr_rel     out  1               release one header credit (1-cycle pulse)
//  o_cr_data_rel    out  1               release data credits (1-cycle pulse)
//  o_cr_data_units  out  9               data credits released, valid with o_cr_data_rel
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (o_hdr, beat counter, length register cleared). Reset mid-TLP aborts
//   with no pointer increment and no credit release.
//  Decode from registered header: fmt = DW0[31:29], has_data = fmt[1], len = DW0[9:0], len==0 -> 1024 DW.
//   beats = ceil(len/DW_PER_BEAT); credits = ceil(len/4) (1..256); rem = len mod DW_PER_BEAT.
//  FSM:
//   IDLE:  if !i_hdr_empty: latch i_hdr_rdata into o_hdr, load beat counter -> SEND_HDR.
//   SEND_HDR: o_hdr_valid=1, o_hdr stable until accepted. On i_hdr_ready:
//     no data -> pulse o_r_hdr_inc and o_cr_hdr_rel, -> IDLE.
//     data    -> SEND_DATA.
//   SEND_DATA: o_data_valid = !i_data_empty. On valid&ready: pulse o_r_data_inc, decrement counter.
//     o_data_last = (counter==1). o_data_keep all-ones except last beat with rem!=0 -> (1<<rem)-1.
//     On last accepted beat (same cycle): pulse o_r_hdr_inc, o_cr_hdr_rel, o_cr_data_rel with
//     o_cr_data_units = credits; -> IDLE.
//  Latency: header entry visible at cycle N -> o_hdr_valid at N+1. Back-to-back TLPs: after return to
//   IDLE, next header valid 2 cycles after previous completion (no overlap of hdr/data phases).
//  Boundaries: data buffer empty mid-payload -> o_data_valid low, counter held, resume on refill.
//   o_data_valid never asserted outside SEND_DATA; o_hdr_valid only in SEND_HDR.
//   ready asserted while valid low has no effect. Pointer wrap handled by buffer control.
//   o_r_*_inc never asserted when corresponding empty flag is high.
// TESTING
//  1 MRd 3DW no data: hdr DW0=0x0000_0001, ready=1 -> o_hdr_valid 1 cycle after, one o_r_hdr_inc and
//    o_cr_hdr_rel pulse, no data pulses, o_cr_data_rel stays 0.
//  2 MWr len=9, DW_PER_BEAT=8 -> 2 beats, keep 0xFF then 0x01, last on beat 2, o_cr_data_units=3.
//  3 MWr len=0 (1024 DW) -> 128 beats, all keep 0xFF, 128 o_r_data_inc pulses, units=256.
//  4 Backpressure: hold i_hdr_ready=0 5 cycles then i_data_ready toggled -> o_hdr stable, beats
//    only counted on valid&ready, no duplicated or lost o_r_data_inc.
//  5 i_data_empty high after beat 1 of 4 for 10 cycles -> o_data_valid low, counter held, then 3 beats.
//  6 Assert i_n_rst low during beat 2 of 4 -> all outputs 0 immediately, no inc/credit pulses;
//    after release, same header re-read and TLP delivered in full.

Source files
------------

// File: rtl/tl_rx_vc_read_ctrl.sv
// Read-side controller for one RX virtual-channel buffer: pops a committed TLP
// (header, then payload beats) onto valid/ready egress streams and returns credits.
module tl_rx_vc_read_ctrl #(
  parameter int HDR_WIDTH      = 128,
  parameter int DATA_WIDTH     = 256,
  parameter int BEAT_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_n_rst,
  input  logic                     i_hdr_empty,
  input  logic                     i_data_empty,
  input  logic [HDR_WIDTH-1:0]     i_hdr_rdata,
  input  logic [DATA_WIDTH-1:0]    i_data_rdata,
  output logic                     o_r_hdr_inc,
  output logic                     o_r_data_inc,
  output logic                     o_hdr_valid,
  input  logic                     i_hdr_ready,
  output logic [HDR_WIDTH-1:0]     o_hdr,
  output logic                     o_data_valid,
  input  logic                     i_data_ready,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic [DATA_WIDTH/32-1:0] o_data_keep,
  output logic                     o_data_last,
  output logic                     o_cr_hdr_rel,
  output logic                     o_cr_data_rel,
  output logic [8:0]               o_cr_data_units
);

  localparam int DW_PER_BEAT = DATA_WIDTH / 32;
  localparam int DPB_LOG2    = $clog2(DW_PER_BEAT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_HDR  = 2'd1,
    SEND_DATA = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q;
  logic [10:0]               len_q;

  logic [10:0]               len_in;
  logic [BEAT_CNT_WIDTH-1:0] beats_in;
  logic                      has_data;
  logic                      hdr_load;
  logic                      data_fire;
  logic                      last_beat;
  logic [10:0]               rem;
  logic [DW_PER_BEAT-1:0]    keep_last;

  // A zero length field encodes the maximum payload of 1024 DW.
  assign len_in   = (i_hdr_rdata[HDR_WIDTH-32 +: 10] == 10'd0) ? 11'd1024
                                                               : {1'b0, i_hdr_rdata[HDR_WIDTH-32 +: 10]};
  assign beats_in = BEAT_CNT_WIDTH'((12'(len_in) + 12'(DW_PER_BEAT - 1)) >> DPB_LOG2);

  assign has_data  = o_hdr[HDR_WIDTH-2];
  assign hdr_load  = (state_q == IDLE) && !i_hdr_empty;
  assign data_fire = (state_q == SEND_DATA) && !i_data_empty && i_data_ready;
  assign last_beat = (beat_cnt_q == BEAT_CNT_WIDTH'(1));
  assign rem       = len_q & 11'(DW_PER_BEAT - 1);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    keep_last = '0;
    for (int i = 0; i < DW_PER_BEAT; i++) begin
      keep_last[i] = (11'(i) < rem);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; o_hdr is a plain
  // register (not a memory), so it is cleared by reset along with the counters.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state_q    <= IDLE;
      o_hdr      <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      state_q <= state_d;
      if (hdr_load) begin
        o_hdr      <= i_hdr_rdata;
        beat_cnt_q <= beats_in;
        len_q      <= len_in;
      end else if (data_fire) begin
        beat_cnt_q <= beat_cnt_q - BEAT_CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!i_hdr_empty) state_d = SEND_HDR;
      SEND_HDR:  if (i_hdr_ready)  state_d = has_data ? SEND_DATA : IDLE;
      SEND_DATA: if (data_fire && last_beat) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Data and keep are forced to zero outside the payload phase so the egress
  // side sees all-quiet outputs while idle or in reset.
  always_comb begin
    o_hdr_valid     = 1'b0;
    o_data_valid    = 1'b0;
    o_data          = '0;
    o_data_keep     = '0;
    o_data_last     = 1'b0;
    o_r_hdr_inc     = 1'b0;
    o_r_data_inc    = 1'b0;
    o_cr_hdr_rel    = 1'b0;
    o_cr_data_rel   = 1'b0;
    o_cr_data_units = '0;
    case (state_q)
      SEND_HDR: begin
        o_hdr_valid = 1'b1;
        if (i_hdr_ready && !has_data) begin
          o_r_hdr_inc  = 1'b1;
          o_cr_hdr_rel = 1'b1;
        end
      end
      SEND_DATA: begin
        o_data_valid = !i_data_empty;
        o_data       = i_data_rdata;
        o_data_last  = last_beat;
        o_data_keep  = (last_beat && rem != 11'd0) ? keep_last : '1;
        if (data_fire) begin
          o_r_data_inc = 1'b1;
          if (last_beat) begin
            o_r_hdr_inc     = 1'b1;
            o_cr_hdr_rel    = 1'b1;
            o_cr_data_rel   = 1'b1;
            o_cr_data_units = 9'((len_q + 11'd3) >> 2);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tl_rx_vc_read_ctrl.sv
// Self-checking bench for tl_rx_vc_read_ctrl: queue-based buffer model plus a
// TLP-level expectation model (headers and beats) built from length/format fields.
module tb_tl_rx_vc_read_ctrl;
  localparam int HW  = 128;
  localparam int DW  = 256;
  localparam int DPB = DW / 32;

  logic            i_clk = 1'b0;
  logic            i_n_rst;
  logic            i_hdr_empty, i_data_empty;
  logic [HW-1:0]   i_hdr_rdata;
  logic [DW-1:0]   i_data_rdata;
  logic            o_r_hdr_inc, o_r_data_inc;
  logic            o_hdr_valid, i_hdr_ready;
  logic [HW-1:0]   o_hdr;
  logic            o_data_valid, i_data_ready;
  logic [DW-1:0]   o_data;
  logic [DPB-1:0]  o_data_keep;
  logic            o_data_last;
  logic            o_cr_hdr_rel, o_cr_data_rel;
  logic [8:0]      o_cr_data_units;

  always #5 i_clk = ~i_clk;

  tl_rx_vc_read_ctrl #(.HDR_WIDTH(HW), .DATA_WIDTH(DW), .BEAT_CNT_WIDTH(8)) dut (
    .i_clk(i_clk), .i_n_rst(i_n_rst),
    .i_hdr_empty(i_hdr_empty), .i_data_empty(i_data_empty),
    .i_hdr_rdata(i_hdr_rdata), .i_data_rdata(i_data_rdata),
    .o_r_hdr_inc(o_r_hdr_inc), .o_r_data_inc(o_r_data_inc),
    .o_hdr_valid(o_hdr_valid), .i_hdr_ready(i_hdr_ready), .o_hdr(o_hdr),
    .o_data_valid(o_data_valid), .i_data_ready(i_data_ready), .o_data(o_data),
    .o_data_keep(o_data_keep), .o_data_last(o_data_last),
    .o_cr_hdr_rel(o_cr_hdr_rel), .o_cr_data_rel(o_cr_data_rel),
    .o_cr_data_units(o_cr_data_units)
  );

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [DPB-1:0] keep;
    logic           last;
    logic [8:0]     units;
  } beat_t;

  // Buffer contents seen by the DUT, and what the egress side must observe.
  logic [HW-1:0] hq[$];
  logic [DW-1:0] dq[$];
  logic [HW-1:0] exp_hdr_q[$];
  beat_t         exp_beat_q[$];
  // Progress of the TLP in flight, kept so a reset can rewind it.
  logic [HW-1:0] cur_hdr;
  beat_t         cur_bdone[$];
  logic [DW-1:0] cur_dpop[$];

  int checks = 0;
  int errors = 0;
  int n_dinc = 0;
  int hv_watch = 0;
  int hdr_mode = 0;
  int data_mode = 0;
  bit in_data = 0;
  bit data_block = 0;
  bit rnd_block = 0;
  bit pop_h, pop_d;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed event without expectation or timeout", tag);
  endtask

  task automatic drive_bufs();
    i_hdr_empty  = (hq.size() == 0);
    i_hdr_rdata  = (hq.size() != 0) ? hq[0] : '0;
    i_data_empty = data_block || (dq.size() == 0);
    i_data_rdata = (dq.size() != 0) ? dq[0] : '0;
  endtask

  // Expected beats come straight from the TLP rules: ceil(len/DPB) beats,
  // partial keep on the last beat, ceil(len/4) credits.
  task automatic push_hdr(input logic [HW-1:0] h);
    int len, nb, rem;
    logic [DW-1:0] d;
    beat_t bt;
    hq.push_back(h);
    exp_hdr_q.push_back(h);
    if (h[HW-2]) begin
      len = (h[HW-32 +: 10] == 10'd0) ? 1024 : int'(h[HW-32 +: 10]);
      nb  = (len + DPB - 1) / DPB;
      rem = len % DPB;
      for (int b = 0; b < nb; b++) begin
        for (int w = 0; w < DPB; w++) d[32*w +: 32] = $urandom;
        dq.push_back(d);
        bt.data  = d;
        bt.last  = (b == nb - 1);
        bt.keep  = (bt.last && rem != 0) ? DPB'((1 << rem) - 1) : {DPB{1'b1}};
        bt.units = bt.last ? 9'((len + 3) / 4) : 9'd0;
        exp_beat_q.push_back(bt);
      end
    end
  endtask

  task automatic push_tlp(input logic [2:0] fmt, input logic [9:0] lenf);
    logic [HW-1:0] h;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[HW-1 -: 3]   = fmt;
    h[HW-32 +: 10] = lenf;
    push_hdr(h);
  endtask

  task automatic check_cycle();
    logic e_hinc, e_hrel, e_drel;
    logic [8:0] e_units;
    logic [HW-1:0] h;
    beat_t b;
    e_hinc = 0; e_hrel = 0; e_drel = 0; e_units = '0;

    if (hv_watch == 1) begin
      chk("hv_gap1", o_hdr_valid, 1'b0);
      hv_watch = 2;
    end else if (hv_watch == 2) begin
      chk("hv_gap2", o_hdr_valid, 1'b1);
      hv_watch = 0;
    end

    chk("dvalid", o_data_valid, in_data && !i_data_empty);
    chk("data_inc", o_r_data_inc, o_data_valid && i_data_ready);
    chk("one_phase", o_hdr_valid && o_data_valid, 1'b0);

    if (o_hdr_valid) begin
      if (exp_hdr_q.size() == 0) fail_now("hdr_unexpected");
      else begin
        chk("hdr", o_hdr, exp_hdr_q[0]);
        if (i_hdr_ready) begin
          h = exp_hdr_q.pop_front();
          if (h[HW-2]) begin
            in_data = 1;
            cur_hdr = h;
            cur_bdone.delete();
            cur_dpop.delete();
          end else begin
            e_hinc = 1; e_hrel = 1;
            if (hq.size() >= 2) hv_watch = 1;
          end
        end
      end
    end

    if (o_data_valid && i_data_ready) begin
      if (exp_beat_q.size() == 0) fail_now("beat_unexpected");
      else begin
        b = exp_beat_q.pop_front();
        cur_bdone.push_back(b);
        chk("data", o_data, b.data);
        chk("keep", o_data_keep, b.keep);
        chk("last", o_data_last, b.last);
        if (b.last) begin
          e_hinc = 1; e_hrel = 1; e_drel = 1; e_units = b.units;
          in_data = 0;
          if (hq.size() >= 2) hv_watch = 1;
        end
      end
    end

    chk("r_hdr_inc", o_r_hdr_inc, e_hinc);
    chk("cr_hdr_rel", o_cr_hdr_rel, e_hrel);
    chk("cr_data_rel", o_cr_data_rel, e_drel);
    chk("cr_data_units", o_cr_data_units, e_units);

    pop_h = o_r_hdr_inc;
    pop_d = o_r_data_inc;
    if (o_r_data_inc) n_dinc++;
  endtask

  task automatic step();
    logic [HW-1:0] th;
    @(negedge i_clk);
    check_cycle();
    @(posedge i_clk);
    #1;
    if (pop_h && hq.size() != 0) th = hq.pop_front();
    if (pop_d && dq.size() != 0) cur_dpop.push_back(dq.pop_front());
    if (hdr_mode == 2) i_hdr_ready = ($urandom_range(0, 3) != 0);
    if (data_mode == 1) i_data_ready = !i_data_ready;
    else if (data_mode == 2) i_data_ready = ($urandom_range(0, 3) != 0);
    if (rnd_block) data_block = ($urandom_range(0, 9) == 0);
    drive_bufs();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_hdr_q.size() != 0 || exp_beat_q.size() != 0 || in_data) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail_now("drain_timeout");
    repeat (3) step();
  endtask

  task automatic wait_beats(input int k, input int budget);
    int n = 0;
    int start = n_dinc;
    while (n_dinc - start < k && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail_now("beat_wait_timeout");
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_hdr_valid"}, o_hdr_valid, 1'b0);
    chk({tag, "_data_valid"}, o_data_valid, 1'b0);
    chk({tag, "_r_hdr_inc"}, o_r_hdr_inc, 1'b0);
    chk({tag, "_r_data_inc"}, o_r_data_inc, 1'b0);
    chk({tag, "_cr_hdr_rel"}, o_cr_hdr_rel, 1'b0);
    chk({tag, "_cr_data_rel"}, o_cr_data_rel, 1'b0);
    chk({tag, "_units"}, o_cr_data_units, 9'd0);
    chk({tag, "_hdr"}, o_hdr, {HW{1'b0}});
    chk({tag, "_data"}, o_data, {DW{1'b0}});
    chk({tag, "_keep"}, o_data_keep, {DPB{1'b0}});
    chk({tag, "_last"}, o_data_last, 1'b0);
  endtask

  initial begin
    int n0, n1;
    i_n_rst = 1'b0;
    i_hdr_ready = 1'b0;
    i_data_ready = 1'b0;
    drive_bufs();
    repeat (2) @(posedge i_clk);
    #1;
    reset_check("rst");
    i_n_rst = 1'b1;

    // Memory read without payload, with header latency check.
    i_hdr_ready = 1'b1;
    i_data_ready = 1'b1;
    n0 = n_dinc;
    push_hdr({32'h0000_0001, $urandom, $urandom, $urandom});
    drive_bufs();
    hv_watch = 1;
    drain(50);
    chk("mrd_no_data_inc", n_dinc - n0, 0);

    // Write with 9 DW: two beats, partial keep on the second.
    n0 = n_dinc;
    push_tlp(3'b010, 10'd9);
    drive_bufs();
    drain(50);
    chk("len9_beats", n_dinc - n0, 2);

    // Maximum payload encoded as length 0.
    n0 = n_dinc;
    push_tlp(3'b011, 10'd0);
    drive_bufs();
    drain(400);
    chk("len1024_beats", n_dinc - n0, 128);

    // Header backpressure, then toggling data ready.
    i_hdr_ready = 1'b0;
    i_data_ready = 1'b0;
    n0 = n_dinc;
    push_tlp(3'b011, 10'd32);
    drive_bufs();
    repeat (6) step();
    i_hdr_ready = 1'b1;
    data_mode = 1;
    drain(100);
    data_mode = 0;
    chk("bp_beats", n_dinc - n0, 4);

    // Data buffer runs dry after the first beat.
    i_data_ready = 1'b1;
    n0 = n_dinc;
    push_tlp(3'b010, 10'd32);
    drive_bufs();
    wait_beats(1, 50);
    data_block = 1;
    drive_bufs();
    n1 = n_dinc;
    repeat (10) step();
    chk("empty_hold", n_dinc - n1, 0);
    data_block = 0;
    drive_bufs();
    drain(50);
    chk("empty_total", n_dinc - n0, 4);

    // Reset while beat 2 of 4 is presented; the whole TLP must be redelivered.
    push_tlp(3'b011, 10'd30);
    drive_bufs();
    wait_beats(1, 50);
    i_n_rst = 1'b0;
    #1;
    reset_check("mid_rst");
    if (in_data) begin
      exp_hdr_q.push_front(cur_hdr);
      for (int i = cur_bdone.size() - 1; i >= 0; i--) exp_beat_q.push_front(cur_bdone[i]);
      for (int i = cur_dpop.size() - 1; i >= 0; i--) dq.push_front(cur_dpop[i]);
      cur_bdone.delete();
      cur_dpop.delete();
      in_data = 0;
    end
    hv_watch = 0;
    @(posedge i_clk);
    #1;
    i_n_rst = 1'b1;
    drive_bufs();
    n1 = n_dinc;
    drain(100);
    chk("rst_redeliver", n_dinc - n1, 4);

    // Randomized traffic with random readiness and data underruns.
    hdr_mode = 2;
    data_mode = 2;
    rnd_block = 1;
    for (int t = 0; t < 25; t++) begin
      push_tlp(3'($urandom_range(0, 7)),
               ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 40)));
    end
    drive_bufs();
    drain(30000);
    rnd_block = 0;
    data_block = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
